// File: rtl/types_pkg.sv
// Shared types for the calculator engine: operation modes, FSM states and the 16-bit word alias.
package types_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    MODE_ADD,
    MODE_SUB,
    MODE_MUL,
    MODE_AND,
    MODE_OR,
    MODE_XOR,
    MODE_SHL,
    MODE_SHR
  } opr_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } calc_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-sample debouncer, registered rising-edge pulse.
// A level held for DEBOUNCE_CYCLES samples yields its pulse DEBOUNCE_CYCLES+2 clocks after the input settles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised sample disagrees with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      pulse_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/calc_engine.sv
// Button-driven calculator: debounced operand/mode controls, single-cycle ALU and a BITS-cycle shift-add multiply.
// Results land on LED the edge after BTNC (or after the multiply completes); buttons are ignored while BUSY.
module calc_engine
  import types_pkg::*;
#(
  parameter int BITS            = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] SW,
  input  logic            BTNC,
  input  logic            BTNU,
  input  logic            BTND,
  input  logic            BTNL,
  input  logic            BTNR,
  output logic [BITS-1:0] LED,
  output opr_mode_t       MODE,
  output logic            BUSY,
  output logic            OVF
);

  localparam int SH_W = $clog2(BITS);

  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level_unused;

  assign btn_raw = {BTNR, BTNL, BTND, BTNU, BTNC};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_raw[i]),
      .level     (btn_level_unused[i]),
      .rise_pulse(btn_pulse[i])
    );
  end

  logic c_p, u_p, d_p, l_p, r_p;
  assign {r_p, l_p, d_p, u_p, c_p} = btn_pulse;

  calc_state_t       state_q, state_d;
  opr_mode_t         mode_q, mode_d;
  logic [BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [BITS-1:0]   led_q, led_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [2*BITS-1:0] mcand_q, mcand_d;
  logic [2*BITS-1:0] prod_q, prod_d;
  logic [BITS-1:0]   mplier_q, mplier_d;
  logic [SH_W-1:0]   step_q, step_d;

  logic [SH_W-1:0]   sh_amt;
  logic [BITS:0]     add_full;
  logic [2*BITS-1:0] shl_full, shr_full, prod_nxt;
  logic [BITS-1:0]   alu_res;
  logic              alu_ovf;

  assign sh_amt   = b_q[SH_W-1:0];
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  // Shifts run in a double-width window so the bits falling off the end can be inspected.
  assign shl_full = {{BITS{1'b0}}, a_q} << sh_amt;
  assign shr_full = {a_q, {BITS{1'b0}}} >> sh_amt;
  assign prod_nxt = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (mode_q)
      MODE_ADD: begin
        alu_res = add_full[BITS-1:0];
        alu_ovf = add_full[BITS];
      end
      MODE_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q < b_q);
      end
      MODE_AND: alu_res = a_q & b_q;
      MODE_OR:  alu_res = a_q | b_q;
      MODE_XOR: alu_res = a_q ^ b_q;
      MODE_SHL: begin
        alu_res = shl_full[BITS-1:0];
        alu_ovf = |shl_full[2*BITS-1:BITS];
      end
      MODE_SHR: begin
        alu_res = shr_full[2*BITS-1:BITS];
        alu_ovf = |shr_full[BITS-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    led_d    = led_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    if (state_q == ST_IDLE) begin
      if (l_p) a_d = SW;
      if (r_p) b_d = SW;
      if (u_p && !d_p) mode_d = opr_mode_t'(mode_q + 3'd1);
      if (d_p && !u_p) mode_d = opr_mode_t'(mode_q - 3'd1);
      // Execution sees the operands and mode as they were before this cycle's loads.
      if (c_p) begin
        if (mode_q == MODE_MUL) begin
          state_d  = ST_MUL;
          busy_d   = 1'b1;
          mcand_d  = {{BITS{1'b0}}, a_q};
          mplier_d = b_q;
          prod_d   = '0;
          step_d   = '0;
        end else begin
          led_d = alu_res;
          ovf_d = alu_ovf;
        end
      end
    end else begin
      prod_d   = prod_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 1'b1;
      if (step_q == SH_W'(BITS - 1)) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        led_d   = prod_nxt[BITS-1:0];
        ovf_d   = |prod_nxt[2*BITS-1:BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ADD;
      a_q      <= '0;
      b_q      <= '0;
      led_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;
  assign BUSY = busy_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_calc_engine.sv
// Randomised and directed bench for calc_engine (BITS=16, DEBOUNCE_CYCLES=4) against an arithmetic reference model.
module tb_calc_engine;
  import types_pkg::*;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  word_t     SW = '0;
  logic      BTNC = 1'b0, BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
  word_t     LED;
  opr_mode_t MODE;
  logic      BUSY, OVF;

  calc_engine #(.BITS(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .SW  (SW),
    .BTNC(BTNC),
    .BTNU(BTNU),
    .BTND(BTND),
    .BTNL(BTNL),
    .BTNR(BTNR),
    .LED (LED),
    .MODE(MODE),
    .BUSY(BUSY),
    .OVF (OVF)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int led_glitch = 0;
  logic [15:0] led_prev = '0;

  // reference state
  int unsigned ma = 0, mb = 0, mmode = 0, mled = 0;
  bit          movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (BUSY) begin
      busy_cnt++;
      if (LED !== led_prev) led_glitch++;
    end
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    {BTNC, BTNU, BTND, BTNL, BTNR} = m;
    repeat (hold) tick();
    {BTNC, BTNU, BTND, BTNL, BTNR} = 5'b0;
    repeat (8) tick();
  endtask

  function automatic void ref_calc(input int unsigned mode, input int unsigned a, input int unsigned b,
                                   output int unsigned led, output bit ovf);
    longint unsigned p;
    int unsigned sh;
    sh  = b % 16;
    led = 0;
    ovf = 1'b0;
    case (mode)
      0: begin p = longint'(a) + b; led = int'(p % 65536); ovf = (p > 65535); end
      1: begin led = (a + 65536 - b) % 65536; ovf = (a < b); end
      2: begin p = longint'(a) * b; led = int'(p % 65536); ovf = (p >= 65536); end
      3: led = a & b;
      4: led = a | b;
      5: led = a ^ b;
      6: begin p = longint'(a) << sh; led = int'(p % 65536); ovf = (p >= 65536); end
      default: begin led = a >> sh; ovf = (a % (32'd1 << sh)) != 0; end
    endcase
  endfunction

  task automatic load_a(input int unsigned v);
    SW = word_t'(v);
    press(B_L, 6);
    ma = v;
  endtask

  task automatic load_b(input int unsigned v);
    SW = word_t'(v);
    press(B_R, 6);
    mb = v;
  endtask

  task automatic goto_mode(input int unsigned target);
    int unsigned fwd;
    for (int n = 0; n < 8 && mmode != target; n++) begin
      fwd = (target + 8 - mmode) % 8;
      if (fwd <= 4) begin
        press(B_U, 6);
        mmode = (mmode + 1) % 8;
      end else begin
        press(B_D, 6);
        mmode = (mmode + 7) % 8;
      end
    end
    chk("mode_nav", 32'(MODE), mmode);
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (BUSY && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk({tag, "_busy_timeout"}, 32'(BUSY), 0);
  endtask

  task automatic exec(input logic [4:0] extra, input string tag);
    int unsigned el;
    bit eo;
    ref_calc(mmode, ma, mb, el, eo);
    led_prev   = 16'(mled);
    busy_cnt   = 0;
    led_glitch = 0;
    press(B_C | extra, 8);
    wait_idle(tag);
    chk({tag, "_busy_cycles"}, busy_cnt, (mmode == 2) ? 16 : 0);
    chk({tag, "_led_hold"}, led_glitch, 0);
    mled = el;
    movf = eo;
    if ((extra & B_L) != 0) ma = SW;
    if ((extra & B_R) != 0) mb = SW;
    chk({tag, "_led"}, 32'(LED), mled);
    chk({tag, "_ovf"}, 32'(OVF), 32'(movf));
  endtask

  task automatic do_op(input int unsigned mode, input int unsigned a, input int unsigned b, input string tag);
    load_a(a);
    load_b(b);
    goto_mode(mode);
    exec(5'b0, tag);
  endtask

  initial begin
    int unsigned el;
    bit eo;
    int seen;

    repeat (3) tick();
    chk("rst_led", 32'(LED), 0);
    chk("rst_mode", 32'(MODE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_ovf", 32'(OVF), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();

    // debounce: a short press is rejected, a long press gives exactly one step
    press(B_U, 3);
    chk("short_press", 32'(MODE), 0);
    press(B_U, 6);
    mmode = 1;
    chk("long_press", 32'(MODE), 1);

    do_op(0, 16'hFFFF, 16'h0002, "add_carry");
    do_op(1, 16'h0001, 16'h0003, "sub_borrow");
    do_op(2, 16'h0123, 16'h0010, "mul_a");
    do_op(2, 16'h0100, 16'h0100, "mul_ovf");

    // BTNU pulse lands while the multiply is busy and must be dropped
    load_a(16'h0007);
    load_b(16'h0009);
    ref_calc(mmode, ma, mb, el, eo);
    led_prev = 16'(mled);
    busy_cnt = 0;
    BTNC = 1'b1;
    repeat (8) tick();
    BTNC = 1'b0;
    BTNU = 1'b1;
    repeat (8) tick();
    BTNU = 1'b0;
    wait_idle("mul_btnu");
    repeat (8) tick();
    mled = el;
    movf = eo;
    chk("mul_btnu_mode", 32'(MODE), 2);
    chk("mul_btnu_busy", busy_cnt, 16);
    chk("mul_btnu_led", 32'(LED), mled);

    goto_mode(0);
    press(B_D, 6);
    mmode = 7;
    chk("d_wrap", 32'(MODE), 7);
    do_op(7, 16'h8001, 16'h0001, "shr");
    do_op(6, 16'h0001, 16'h0013, "shl");

    press(B_U | B_D, 6);
    chk("u_and_d", 32'(MODE), mmode);

    // load and execute in one cycle: result uses the old A
    SW = 16'h0005;
    exec(B_L, "l_with_c");
    exec(5'b0, "after_l");

    // asynchronous reset in the middle of a multiply
    load_a(16'h1234);
    load_b(16'h00FF);
    goto_mode(2);
    seen = 0;
    BTNC = 1'b1;
    for (int i = 0; i < 40 && seen < 8; i++) begin
      tick();
      if (i == 7) BTNC = 1'b0;
      if (BUSY) seen++;
    end
    BTNC = 1'b0;
    chk("rst_mul_seen", seen, 8);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_led", 32'(LED), 0);
    chk("arst_mode", 32'(MODE), 0);
    ma = 0; mb = 0; mmode = 0; mled = 0; movf = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    do_op(2, 16'h00C3, 16'h0101, "mul_post_rst");

    for (int k = 0; k < 20; k++) begin
      do_op($urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 65535), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
Sequential successor to the combinational SW→LED operation selector used on the board and emulator bench.
- Debounces the five push-buttons.
- Latches two operands from SW and cycles the operation mode with buttons.
- Executes on BTNC, including a multi-cycle shift-add multiply, and holds the result on LED.
- Sits directly under the board top level; the emulator bench drives it through its file-backed SW/LED loop.

Parameters:
BITS, 16, operand/result width (≥4)
DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted (≥2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
SW  input  BITS  operand source
BTNC  input  1  execute
BTNU  input  1  next mode
BTND  input  1  previous mode
BTNL  input  1  load operand A from SW
BTNR  input  1  load operand B from SW
LED  output  BITS  result register
MODE  output  opr_mode_t  current operation
BUSY  output  1  multiply in progress
OVF  output  1  overflow/borrow flag of last result

Behaviour:
- Reset (rst=0, async): A=B=0, LED=0, MODE=ADD, BUSY=0, OVF=0, FSM=IDLE, debouncer sync flops, counters and accepted levels = 0. Release is synchronous to clk.
- Button path (each button):
  - 2-flop synchroniser feeds a counter; the accepted level changes after DEBOUNCE_CYCLES consecutive samples that differ from it. Any equal sample clears the counter.
  - A one-cycle pulse is emitted on an accepted 0→1 transition only.
  - Latency from stable input to pulse: DEBOUNCE_CYCLES+2 clk.
- Modes, in order: ADD, SUB, MUL, AND, OR, XOR, SHL, SHR.
  - U pulse advances MODE; wraps SHR→ADD.
  - D pulse retreats MODE; wraps ADD→SHR.
  - U and D in the same cycle: MODE unchanged.
- L pulse: A←SW. R pulse: B←SW. Both take effect the cycle after the pulse; L and R in the same cycle load both.
- C pulse in IDLE starts execution with the current A, B, MODE. L/R/U/D pulses in that same cycle also apply, but execution uses the pre-update values.
- FSM states: IDLE, MUL.
  - Single-cycle ops (IDLE→IDLE): LED/OVF update on the clock edge after the C pulse.
  - ADD: LED=(A+B)[BITS-1:0], OVF=carry out.
  - SUB: LED=A−B mod 2^BITS, OVF=(A<B) unsigned.
  - AND/OR/XOR: bitwise, OVF=0.
  - SHL/SHR: logical shift of A by B[$clog2(BITS)-1:0]; OVF=1 if any nonzero bit shifted out.
  - MUL: IDLE→MUL, BUSY=1 on the next cycle. Shift-add runs for exactly BITS cycles, then returns to IDLE with BUSY=0.
  - MUL result: LED=product[BITS-1:0], OVF=|product[2*BITS-1:BITS]. LED holds its old value until completion.
- While BUSY, all button pulses are discarded. They are not queued, and they do not change A, B or MODE.
- LED and OVF change only on completion of an execute; they hold otherwise.
- rst asserted mid-multiply aborts it; all state returns to reset values.

Decomposition:
- types_pkg: extend opr_mode_t with the eight modes above, in the order listed; word_t stays the BITS=16 alias; add a calc_state_t enum {IDLE, MUL}.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_in, level, rise_pulse), instantiated five times.
- The FSM, operand registers and ALU stay in calc_engine.

Test Plan (BITS=16, DEBOUNCE_CYCLES=4):
- Reset then release: LED=0, MODE=ADD, BUSY=0. Hold BTNU high 3 cycles then low: no mode change. Hold 6 cycles: MODE=SUB, exactly one pulse.
- SW=0xFFFF, BTNL; SW=0x0002, BTNR; BTNC in ADD: LED=0x0001, OVF=1. Then select SUB with A=0x0001, B=0x0003: LED=0xFFFE, OVF=1.
- MUL with A=0x0123, B=0x0010: BUSY high exactly 16 cycles, then LED=0x1230, OVF=0. With A=B=0x0100: LED=0x0000, OVF=1. BTNU pressed during BUSY: MODE stays MUL.
- Press BTND from ADD: MODE=SHR. SHR with A=0x8001, B=0x0001: LED=0x4000, OVF=1. SHL with B=0x0013 (amount 3), A=0x0001: LED=0x0008, OVF=0.
- BTNU and BTND stable-accepted in the same cycle: MODE unchanged. BTNL and BTNC in the same cycle: result uses old A, and A updates.
- rst=0 at cycle 8 of a multiply: BUSY=0, LED=0, MODE=ADD immediately (asynchronous). The next multiply completes normally.
